// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot arbiter and the memory it drives.
package imem_pkg;
    localparam int          DEFAULT_DEPTH = 64;
    localparam int          DEFAULT_AW    = 6;
    localparam logic [31:0] DEFAULT_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;
endpackage

// File: rtl/imem_boot_arbiter_byte_packer.sv
// Packs loader bytes little-endian into a 32-bit word; flags when the word is ready to write.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    input  logic        byte_last,
    output logic [31:0] pack,
    output logic        word_done
);
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pack_q, pack_d;

    always_comb begin
        cnt_d  = cnt_q;
        pack_d = pack_q;
        if (clr) begin
            cnt_d  = 2'd0;
            pack_d = 32'd0;
        end else if (byte_vld) begin
            pack_d[{cnt_q, 3'b000} +: 8] = byte_in;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // A short final word is written as-is; its unfilled lanes are still zero from the last clear.
    assign word_done = byte_vld && ((cnt_q == 2'd3) || byte_last);
    assign pack      = pack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            pack_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
        end
    end
endmodule

// File: rtl/imem_boot_arbiter.sv
// Shares a single-port instruction memory between a byte-serial boot loader and the core fetch port.
module imem_boot_arbiter
    import imem_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter int          AW        = DEFAULT_AW,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          core_req,
    input  logic [31:0]   core_addr,
    output logic [31:0]   core_instr,
    output logic          core_valid,
    output logic          core_fault,
    output logic          core_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [AW:0]   load_words
);
    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   lw_q, lw_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;
    logic [31:0]   instr_q, instr_d;

    logic          accept, pk_clr, word_done, full, fetch, bad_addr;
    logic [31:0]   pack;
    logic [29:0]   lw_ext;

    assign ld_ready   = (state_q == ST_LOAD);
    assign accept     = ld_valid && ld_ready;
    assign core_stall = (state_q != ST_RUN);
    assign full       = (ptr_q == AW'(DEPTH - 1));

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pk_clr),
        .byte_vld  (accept),
        .byte_in   (ld_byte),
        .byte_last (ld_last),
        .pack      (pack),
        .word_done (word_done)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lw_d      = lw_q;
        last_d    = last_q;
        pk_clr    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = pack;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    last_d = last_q || ld_last;
                    if (word_done) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                pk_clr = 1'b1;
                last_d = 1'b0;
                // The pointer parks on the last word so a full memory never wraps onto word 0.
                ptr_d  = full ? ptr_q : ptr_q + 1'b1;
                if (last_q || full) begin
                    lw_d    = {1'b0, ptr_q} + 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                mem_addr = core_addr[AW+1:2];
                if (ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    lw_d    = '0;
                    last_d  = 1'b0;
                    pk_clr  = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // A fetch accepted alongside ld_start still answers next cycle; the LOAD state blocks later ones.
    assign lw_ext   = {{(30 - AW - 1){1'b0}}, lw_q};
    assign fetch    = core_req && (state_q == ST_RUN);
    assign bad_addr = (core_addr[1:0] != 2'b00) || (core_addr[31:2] >= lw_ext);

    always_comb begin
        valid_d = fetch;
        fault_d = fetch && bad_addr;
        instr_d = instr_q;
        if (fetch) instr_d = bad_addr ? NOP_INSTR : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            lw_q    <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lw_q    <= lw_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            instr_q <= instr_d;
        end
    end

    assign core_valid = valid_q;
    assign core_fault = fault_q;
    assign core_instr = instr_q;
    assign load_words = lw_q;
endmodule

// File: doc/imem_boot_arbiter.md
Name: imem_boot_arbiter

Overview:
Shares the single-port instruction memory between a byte-serial program loader and the core's fetch port. After reset it holds the core in stall and loads the program. Loader bytes are packed little-endian into 32-bit words and written to sequential word addresses. It then releases the core and serves registered instruction fetches until a reload is requested.

Parameters:
DEPTH, 64, number of 32-bit words in the instruction memory
AW, 6, word-address width, equal to clog2(DEPTH)
NOP_INSTR, 32'h00000013, word returned for a faulting fetch (addi x0,x0,0)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ld_start  input  1  pulse: abandon RUN and restart loading at word 0
ld_valid  input  1  loader byte valid
ld_byte  input  8  loader data byte
ld_last  input  1  qualifies ld_valid: this byte ends the program
ld_ready  output  1  loader byte accepted when ld_valid and ld_ready
core_req  input  1  fetch request from core
core_addr  input  32  byte address of fetch
core_instr  output  32  fetched instruction, registered
core_valid  output  1  core_instr valid, one-cycle pulse per request
core_fault  output  1  registered with core_valid: misaligned or out-of-range fetch
core_stall  output  1  core must hold PC; high in all states except RUN
mem_we  output  1  memory write enable
mem_addr  output  AW  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, combinational from mem_addr
load_words  output  AW+1  number of words written by the last load, valid in RUN

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=LOAD.
  - Byte counter, word pointer and load_words go to 0; the pack register is cleared.
  - core_valid=0, core_fault=0, core_instr=NOP_INSTR, core_stall=1, ld_ready=1, mem_we=0.
- LOAD state:
  - ld_ready=1 except in the WRITE cycle.
  - Each accepted byte k (k = byte counter 0..3) goes into pack[8k+7:8k].
  - After byte 3 is accepted, or after ld_last with a partial word (unfilled bytes are zero), go to WRITE.
- WRITE state (1 cycle):
  - mem_we=1, mem_addr=word pointer, mem_wdata=pack.
  - Word pointer increments; byte counter and pack are cleared.
  - If ld_last was seen, latch load_words=pointer+1 and go to RUN. Otherwise return to LOAD.
- Full memory:
  - A word written at pointer DEPTH-1 forces the move to RUN even without ld_last; load_words=DEPTH.
  - Pointer never wraps; excess bytes are refused (ld_ready=0 in RUN).
- ld_last on byte 3 completes the word normally; there is no extra write.
- RUN state:
  - core_stall=0, ld_ready=0.
  - Memory is driven by the fetch: mem_addr=core_addr[AW+1:2], mem_we=0.
  - core_req in cycle N gives core_valid=1 in cycle N+1, with core_instr=mem_rdata sampled at N.
  - Back-to-back requests give one result per cycle.
- Fault:
  - A fetch faults if core_addr[1:0]!=0, or core_addr[31:2]>=load_words.
  - On a fault, core_instr=NOP_INSTR and core_fault=1 in the response cycle.
- ld_start in RUN:
  - Next state is LOAD; pointer, byte counter and load_words are cleared.
  - A fetch issued in the same cycle still completes its response in the next cycle. No new fetch is accepted afterwards.
  - ld_start in LOAD or WRITE is ignored.
- ld_valid without ld_ready has no effect. The loader must hold the byte.
- Reset mid-load discards the partial word; memory contents already written are not changed.

Decomposition:
- Shared package imem_pkg:
  - state encoding LOAD/WRITE/RUN
  - NOP_INSTR constant
  - DEPTH/AW defaults, shared with the instruction memory
- One natural sub-module: byte_packer. It holds the byte counter, the pack register and the word-complete strobe, with a clear input.

Test Plan:
1. Reset, then load bytes 13,05,A0,00 and 13,01,40,01 with ld_last on the last byte → mem writes word0=0x00A00513 and word1=0x01400113. State enters RUN two cycles after the final byte; load_words=2; core_stall falls.
2. RUN: core_req with core_addr=0x0 then 0x4 on consecutive cycles → core_valid pulses on the next two cycles with 0x00A00513 then 0x01400113; core_fault=0.
3. Partial word: load 3 bytes 93,02,10 with ld_last on the third → word0=0x00100293; load_words=1.
4. Faults after a 2-word load:
   - core_addr=0x8 → core_instr=0x00000013, core_fault=1.
   - core_addr=0x2 → core_fault=1.
5. Fill 64 words without ld_last → RUN after the 64th write; load_words=64; ld_ready stays 0 while ld_valid is held high.
6. ld_start while core_req=1 at 0x0 → that fetch's response still arrives; core_stall=1 the next cycle. Drop rst_n in the middle of a subsequent byte → outputs return to reset values immediately.
